// File: rtl/or1200_keccak_pkg.sv
// Shared definitions for the OR1200 Keccak command sequencer.
// Contents: default widths, l.cust5 sub-opcodes, FSM state encoding.
package or1200_keccak_pkg;

   localparam int DW_DEF = 32;
   localparam int OW_DEF = 512;
   localparam int NW_DEF = OW_DEF / DW_DEF;

   // cust5_op sub-opcodes; every other value is illegal.
   localparam logic [4:0] OP_INIT   = 5'd0;
   localparam logic [4:0] OP_END    = 5'd1;
   localparam logic [4:0] OP_MIDDLE = 5'd2;
   localparam logic [4:0] OP_START  = 5'd4;
   localparam logic [4:0] OP_STORE  = 5'd8;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ABSORB      = 3'd1,
      ST_ABSORB_WAIT = 3'd2,
      ST_PERMUTE     = 3'd3,
      ST_DONE        = 3'd4
   } state_t;

endpackage

// File: rtl/or1200_keccak_digest_mux.sv
// Digest register with NW:1 word select.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the digest to zero
//   load       : capture d into the digest (clr has priority)
//   d          : full digest from the core
//   idx        : word index
//   word       : digest[DW*idx +: DW]
module or1200_keccak_digest_mux
   import or1200_keccak_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int OW = OW_DEF,
   parameter int NW = OW / DW,
   parameter int IW = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic [OW-1:0] d,
   input  logic [IW-1:0] idx,
   output logic [DW-1:0] word
);

   logic [OW-1:0] digest;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digest <= '0;
      end else if (clr) begin
         digest <= '0;
      end else if (load) begin
         digest <= d;
      end
   end

   assign word = digest[DW*idx +: DW];

endmodule

// File: rtl/or1200_keccak_seq.sv
// Keccak command sequencer: turns l.cust5 commands from the EX stage into
// a word stream for the Keccak core and serves digest words back.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset (sync release)
//   cmd_valid/op/idx/data, cmd_ready, freeze_req : command side
//   k_init, k_in, k_in_valid, k_in_last, k_in_ready : core input side
//   k_out, k_out_valid : core digest and its one-cycle strobe
//   rd_data, rd_valid : STORE result and its one-cycle strobe
//   busy, err         : status; err is sticky until INIT
//   state_dbg, word_cnt : FSM state and handshake counter
//
// Handshake rule (both sides): a transfer happens on the rising edge where
// valid and ready are both 1. The producer keeps its payload stable while
// valid=1 and ready=0. cmd_ready is a decode of state and cmd_op and does
// not depend on cmd_valid.
module or1200_keccak_seq
   import or1200_keccak_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int OW = OW_DEF,
   parameter int NW = OW / DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   input  logic [4:0]    cmd_op,
   input  logic [5:0]    cmd_idx,
   input  logic [DW-1:0] cmd_data,
   output logic          cmd_ready,
   output logic          freeze_req,
   output logic          k_init,
   output logic [DW-1:0] k_in,
   output logic          k_in_valid,
   output logic          k_in_last,
   input  logic          k_in_ready,
   input  logic [OW-1:0] k_out,
   input  logic          k_out_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          busy,
   output logic          err,
   output state_t        state_dbg,
   output logic [7:0]    word_cnt
);

   localparam int IW = (NW > 1) ? $clog2(NW) : 1;

   state_t        state;
   logic          rst_meta;
   logic          rst_n_sync;
   logic          accept;
   logic          dig_clr;
   logic          dig_load;
   logic [DW-1:0] dig_word;
   logic          unused_idx;

   // Reset asserts asynchronously, releases two clocks later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta   <= 1'b0;
         rst_n_sync <= 1'b0;
      end else begin
         rst_meta   <= 1'b1;
         rst_n_sync <= rst_meta;
      end
   end

   // While a word is waiting on the core only INIT (abort) and STORE can be
   // taken; nothing is taken during the permutation.
   always_comb begin
      cmd_ready = 1'b1;
      case (state)
         ST_ABSORB_WAIT: cmd_ready = (cmd_op == OP_INIT) || (cmd_op == OP_STORE);
         ST_PERMUTE:     cmd_ready = 1'b0;
         default:        cmd_ready = 1'b1;
      endcase
   end

   assign accept     = cmd_valid & cmd_ready;
   assign freeze_req = cmd_valid & ~cmd_ready;
   assign busy       = (state == ST_ABSORB_WAIT) || (state == ST_PERMUTE);
   assign state_dbg  = state;
   assign dig_clr    = accept && (cmd_op == OP_INIT);
   assign dig_load   = (state == ST_PERMUTE) && k_out_valid;
   assign unused_idx = ^cmd_idx[5:IW];

   or1200_keccak_digest_mux #(
      .DW (DW),
      .OW (OW),
      .NW (NW),
      .IW (IW)
   ) u_digest (
      .clk   (clk),
      .rst_n (rst_n_sync),
      .clr   (dig_clr),
      .load  (dig_load),
      .d     (k_out),
      .idx   (cmd_idx[IW-1:0]),
      .word  (dig_word)
   );

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state      <= ST_IDLE;
         k_init     <= 1'b0;
         k_in       <= '0;
         k_in_valid <= 1'b0;
         k_in_last  <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         err        <= 1'b0;
         word_cnt   <= 8'd0;
      end else begin
         k_init   <= 1'b0;
         rd_valid <= 1'b0;

         if (state == ST_ABSORB_WAIT && k_in_valid && k_in_ready) begin
            k_in_valid <= 1'b0;
            if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
            state <= k_in_last ? ST_PERMUTE : ST_ABSORB;
         end

         if (dig_load) state <= ST_DONE;

         // Command handling comes last so an INIT abort overrides a core
         // handshake completing in the same cycle.
         if (accept) begin
            case (cmd_op)
               OP_INIT: begin
                  k_init     <= 1'b1;
                  k_in_valid <= 1'b0;
                  k_in_last  <= 1'b0;
                  word_cnt   <= 8'd0;
                  err        <= 1'b0;
                  state      <= ST_IDLE;
               end
               OP_START: begin
                  if (state == ST_IDLE || state == ST_DONE) begin
                     k_in       <= cmd_data;
                     k_in_valid <= 1'b1;
                     k_in_last  <= 1'b0;
                     word_cnt   <= 8'd0;
                     state      <= ST_ABSORB_WAIT;
                  end else begin
                     err <= 1'b1;
                  end
               end
               OP_MIDDLE, OP_END: begin
                  if (state == ST_ABSORB) begin
                     k_in       <= cmd_data;
                     k_in_valid <= 1'b1;
                     k_in_last  <= (cmd_op == OP_END);
                     state      <= ST_ABSORB_WAIT;
                  end else begin
                     err <= 1'b1;
                  end
               end
               OP_STORE: begin
                  rd_valid <= 1'b1;
                  if (state == ST_DONE) begin
                     rd_data <= dig_word;
                  end else begin
                     rd_data <= '0;
                     err     <= 1'b1;
                  end
               end
               default: err <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: doc/or1200_keccak_seq.md
OR1200_KECCAK_SEQ -- requirements
Module: or1200_keccak_seq

Interface
REQ-001 Parameters: DW, default 32, command data/result word width; OW, default 512, digest width; NW = OW/DW, default 16, digest word count.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset); release is synchronised to clk.
REQ-004 cmd_valid  input  1  l.cust5 issued from EX stage.
REQ-005 cmd_op  input  5  cust5_op: 0 INIT, 4 START, 2 MIDDLE, 1 END, 8 STORE; any other value is illegal.
REQ-006 cmd_idx  input  6  cust5_limm; STORE word index, bits [3:0] used.
REQ-007 cmd_data  input  DW  rA operand; the absorb word.
REQ-008 cmd_ready  output  1  command accepted this cycle when cmd_valid=1.
REQ-009 freeze_req  output  1  equals cmd_valid & ~cmd_ready; pipeline stall request.
REQ-010 k_init  output  1  one-cycle core state clear.
REQ-011 k_in  output  DW  word to core; k_in_valid output 1; k_in_last output 1; k_in_ready input 1.
REQ-012 k_out  input  OW  core digest; k_out_valid input 1, one-cycle digest strobe.
REQ-013 rd_data  output  DW  STORE result; rd_valid output 1, one-cycle strobe.
REQ-014 busy  output  1  high in ABSORB_WAIT or PERMUTE; err  output  1  sticky protocol error flag.

Function
REQ-015 FSM states: IDLE, ABSORB, ABSORB_WAIT, PERMUTE, DONE.
REQ-016 INIT, any state except PERMUTE: accepted; k_init pulses next cycle; counter, err and digest register cleared; next state IDLE.
REQ-017 INIT in PERMUTE: cmd_ready=0 until k_out_valid has been seen.
REQ-018 START, from IDLE or DONE: word latched to k_in; k_in_valid=1 next cycle; k_in_last=0; next state ABSORB_WAIT.
REQ-019 MIDDLE, from ABSORB: same handling as START.
REQ-020 END, from ABSORB: same handling but k_in_last=1; on handshake the next state is PERMUTE.
REQ-021 START in ABSORB, or MIDDLE/END in IDLE/DONE: command accepted, no core activity, err set.
REQ-022 In ABSORB_WAIT, k_in, k_in_valid and k_in_last are held stable until k_in_ready=1.
REQ-023 Core handshake completes in the cycle where k_in_valid & k_in_ready; next state is ABSORB, or PERMUTE for END.
REQ-024 cmd_ready=0 in ABSORB_WAIT and PERMUTE, except that STORE/INIT wait only in PERMUTE.
REQ-025 In PERMUTE, k_out_valid captures k_out into the digest register; next state DONE.
REQ-026 STORE in DONE: rd_data = digest[DW*idx +: DW], rd_valid=1 exactly one cycle after acceptance.
REQ-027 STORE in PERMUTE: stalled until DONE, then served.
REQ-028 STORE in IDLE/ABSORB: rd_data=0, rd_valid=1, err set.
REQ-029 Illegal cmd_op: accepted, ignored, err set.
REQ-030 k_out_valid outside PERMUTE: ignored.
REQ-031 Word counter (8 bit): increments on each core handshake, saturates at 255, cleared on START and INIT.
REQ-032 At most one command accepted per cycle; no command is ever dropped while freeze_req=1.

Reset
REQ-033 Reset values: state IDLE; every output 0, except cmd_ready = 1 when cmd_valid is legal in IDLE; digest register 0; counter 0; err 0.
REQ-034 Reset mid-operation aborts any pending core handshake immediately; k_in_valid drops asynchronously.

Structure
REQ-035 Shared package or1200_keccak_pkg: cust5 op codes, FSM state encoding, DW/OW/NW defaults.
REQ-036 One sub-module, or1200_keccak_digest_mux: digest register plus NW:1 word select.

Verification
REQ-037 Sequence INIT, START 1, MIDDLE 2..6, END 7, with k_in_ready always 1: 7 core handshakes, k_in_last only on word 7, counter=7, state PERMUTE, err=0.
REQ-038 Hold k_in_ready=0 for 5 cycles during MIDDLE 3: k_in=3 stable; freeze_req=1 for a following MIDDLE; no word lost or duplicated.
REQ-039 k_out_valid with k_out[63:32]=0xDEADBEEF, then STORE idx 1: rd_data=0xDEADBEEF, rd_valid one cycle after acceptance; STORE idx 15 returns k_out[511:480].
REQ-040 STORE issued during PERMUTE: freeze_req=1 until k_out_valid; rd_valid comes 1 cycle after DONE is entered.
REQ-041 MIDDLE from IDLE, and op 5: err=1, no k_in_valid; a following INIT clears err.
REQ-042 rst low during ABSORB_WAIT: k_in_valid=0 immediately; after release state IDLE, counter 0.
